// File: rtl/pipeline_defs.sv
// Shared definitions for the front end of the pipeline.
//   NOP_INSTR        : encoding presented downstream when no instruction is valid
//   INSTR_W / PC_W   : instruction and program-counter widths
//   DEFAULT_RESET_PC : PC the fetch stage starts from unless overridden
//   fetch_entry_t    : one buffered fetch result, {pc, instr}
package pipeline_defs;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int ENTRY_W = PC_W + INSTR_W;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [PC_W-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} words.
//   clk, rst_n : clock and asynchronous active-low reset (control state only)
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   flush_i    : discard all entries; overrides push and pop
//   rdata_o    : head entry, read combinationally from registered storage
//   empty_o, full_o, count_o : occupancy status
module fetch_fifo
    import pipeline_defs::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order requests to
// instruction memory, buffers returned words and presents the oldest one
// to the IF/ID register.
//   clk, reset        : clock; asynchronous active-low reset
//   stall             : hold the presented entry (no pop)
//   redirect_valid/pc : flush everything and restart fetch at redirect_pc
//   imem_req/addr     : request out (handshake with imem_ready)
//   imem_rvalid/rdata : in-order responses
//   out_valid, currpc, nextpc, out_instn : head entry, zeros/NOP when empty
module if_fetch_stage
    import pipeline_defs::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    output logic [PC_W-1:0]    currpc,
    output logic [PC_W-1:0]    nextpc,
    output logic [INSTR_W-1:0] out_instn
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   in_use;
    logic             fifo_empty, fifo_full;
    logic             fifo_push, fifo_pop;
    logic             handshake, resp_ok;
    logic [PC_W-1:0]  redir_tgt;
    fetch_entry_t     push_entry, head;

    assign redir_tgt = redirect_pc & ~32'h3;

    // Credit: every issued request already owns a buffer slot, so the
    // FIFO cannot overflow regardless of stall.
    assign in_use    = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req  = reset && !redirect_valid && (in_use < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_addr = pc_q;
    assign handshake = imem_req & imem_ready;
    // A response with nothing outstanding (e.g. left over from before a
    // reset) is ignored entirely.
    assign resp_ok   = imem_rvalid & (outstanding_q != '0);

    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};
    assign fifo_pop   = !fifo_empty && !stall && !redirect_valid;

    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        fifo_push     = 1'b0;
        outstanding_d = outstanding_q + CNT_W'(handshake) - CNT_W'(resp_ok);
        if (handshake) pc_d = pc_q + 32'd4;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the
            // abandoned path, including a response landing right now.
            pc_d       = redir_tgt;
            resp_pc_d  = redir_tgt;
            drop_cnt_d = outstanding_d;
        end else if (resp_ok) begin
            if (drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end else begin
                fifo_push = 1'b1;
                resp_pc_d = resp_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect_valid),
        .wdata_i (push_entry),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign currpc    = fifo_empty ? '0 : head.pc;
    assign nextpc    = fifo_empty ? '0 : head.pc + 32'd4;
    assign out_instn = fifo_empty ? NOP_INSTR : head.instr;

    a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!reset)
        imem_rvalid |-> (outstanding_q != '0))
        else $warning("if_fetch_stage: imem_rvalid with nothing outstanding, word ignored");

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        fifo_push |-> !fifo_full)
        else $error("if_fetch_stage: push into full fetch buffer");

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic [31:0] currpc, nextpc, out_instn;

    // second instance exercising PC wrap from a high reset PC
    logic        w_stall = 1'b0;
    logic        w_redir = 1'b0;
    logic [31:0] w_rpc = 32'h0;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = 32'h0;
    logic        w_valid;
    logic [31:0] w_curr, w_next, w_instn;

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .currpc(currpc), .nextpc(nextpc), .out_instn(out_instn)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .reset(reset), .stall(w_stall),
        .redirect_valid(w_redir), .redirect_pc(w_rpc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .out_valid(w_valid), .currpc(w_curr), .nextpc(w_next), .out_instn(w_instn)
    );

    typedef struct { logic [31:0] pc; logic [31:0] npc; logic [31:0] ins; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { int n; bit st; bit rd; logic [31:0] rpc; int lat; int req; int vld; } vec_t;

    exp_t  sb[$];
    pend_t pend[$];
    vec_t  vec[$];

    int          n_pass = 0, n_chk = 0, n_out = 0;
    int          cyc = 0, lat = 1, last_due = 0, w_pops = 0;
    logic [31:0] exp_pc = 32'h0;
    bit          inject_spurious = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_pc = 32'h0, prev_ins = 32'h0;
    bit          w_hs_prev = 1'b0;
    logic [31:0] w_addr_prev = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A3C_0F13;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: drive at negedge, sample 1ns later, advance to next negedge.
    // req/vld: expected imem_req/out_valid, 2 = not checked this cycle.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                        input int req, input int vld);
        int          due;
        exp_t        e;
        logic [31:0] wp;
        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        if (inject_spurious) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            inject_spurious = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        w_rvalid = w_hs_prev;
        w_rdata  = w_hs_prev ? instr_of(w_addr_prev) : 32'h0;
        #1;
        if (req != 2) check("imem_req", 32'(imem_req), 32'(req));
        if (vld != 2) check("out_valid", 32'(out_valid), 32'(vld));
        if (prev_hold && !rd) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_currpc", currpc, prev_pc);
            check("hold_instn", out_instn, prev_ins);
        end
        if (imem_req && imem_ready) begin
            check("imem_addr", imem_addr, exp_pc);
            sb.push_back('{pc: exp_pc, npc: exp_pc + 32'd4, ins: instr_of(exp_pc)});
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: imem_addr, due: due});
            exp_pc += 32'd4;
        end
        if (rd) begin
            sb.delete();
            exp_pc = {rpc[31:2], 2'b00};
        end
        if (out_valid && !st && !rd) begin
            n_out++;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output: got currpc %h, expected no entry", currpc);
            end else begin
                e = sb.pop_front();
                check("currpc", currpc, e.pc);
                check("nextpc", nextpc, e.npc);
                check("out_instn", out_instn, e.ins);
            end
        end
        check("inflight_bound", 32'(sb.size() <= 2), 32'd1);
        prev_hold = out_valid && st && !rd;
        prev_pc   = currpc;
        prev_ins  = out_instn;
        if (w_valid && w_pops < 3) begin
            wp = 32'hFFFF_FFF8 + 32'(4 * w_pops);
            check("wrap_currpc", w_curr, wp);
            check("wrap_nextpc", w_next, wp + 32'd4);
            check("wrap_instn", w_instn, instr_of(wp));
            w_pops++;
        end
        w_hs_prev   = w_req && imem_ready;
        w_addr_prev = w_addr;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic progress(input string name, input int since);
        check(name, 32'(n_out > since), 32'd1);
    endtask

    initial begin
        int mark;
        bit found;
        // n, stall, redirect, redirect_pc, latency, exp_req, exp_vld
        vec.push_back('{1, 0, 0, 32'h0,   1, 1, 0});  // first cycle after release
        vec.push_back('{1, 0, 0, 32'h0,   1, 1, 0});
        vec.push_back('{1, 0, 0, 32'h0,   1, 0, 1});  // 1 in flight + 1 buffered
        vec.push_back('{1, 0, 0, 32'h0,   1, 1, 1});
        vec.push_back('{6, 0, 0, 32'h0,   1, 2, 2});
        vec.push_back('{2, 1, 0, 32'h0,   1, 2, 2});  // stall: buffer fills
        vec.push_back('{3, 1, 0, 32'h0,   1, 0, 1});  // full: no requests
        vec.push_back('{6, 0, 0, 32'h0,   1, 2, 2});
        vec.push_back('{6, 0, 0, 32'h0,   4, 2, 2});  // long latency builds in-flight
        vec.push_back('{1, 0, 1, 32'h103, 1, 0, 2});  // redirect with requests in flight
        vec.push_back('{1, 0, 0, 32'h0,   1, 2, 0});
        vec.push_back('{12, 0, 0, 32'h0,  1, 2, 2});
        vec.push_back('{1, 1, 1, 32'h40,  1, 0, 2});  // redirect wins over stall
        vec.push_back('{1, 0, 0, 32'h0,   1, 2, 0});
        vec.push_back('{8, 0, 0, 32'h0,   1, 2, 2});
        vec.push_back('{1, 0, 1, 32'h200, 1, 0, 2});  // back-to-back redirects
        vec.push_back('{1, 0, 1, 32'h300, 1, 0, 0});
        vec.push_back('{1, 0, 0, 32'h0,   1, 2, 0});
        vec.push_back('{10, 0, 0, 32'h0,  1, 2, 2});

        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_currpc", currpc, 32'h0);
        check("rst_nextpc", nextpc, 32'h0);
        check("rst_out_instn", out_instn, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        mark = n_out;
        for (int i = 0; i < vec.size(); i++) begin
            for (int k = 0; k < vec[i].n; k++) begin
                lat = vec[i].lat;
                step(vec[i].st, vec[i].rd, vec[i].rpc, vec[i].req, vec[i].vld);
            end
        end
        progress("table_progress", mark);
        check("wrap_outputs_seen", 32'(w_pops), 32'd3);

        // response lands in the redirect cycle
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend.size() > 0 && pend[0].due == cyc) found = 1'b1;
            else step(0, 0, 32'h0, 2, 2);
        end
        check("resp_in_redirect_setup", 32'(found), 32'd1);
        step(0, 1, 32'h500, 0, 2);
        step(0, 0, 32'h0, 2, 0);
        mark = n_out;
        for (int i = 0; i < 10; i++) step(0, 0, 32'h0, 2, 2);
        progress("after_redirect_progress", mark);

        // reset with requests in flight
        lat = 4;
        for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 2, 2);
        #2 reset = 1'b0;
        #1;
        check("async_rst_imem_req", 32'(imem_req), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_currpc", currpc, 32'h0);
        check("async_rst_nextpc", nextpc, 32'h0);
        check("async_rst_out_instn", out_instn, 32'h0);
        check("async_rst_wrap_valid", 32'(w_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc++;
        sb.delete();
        pend.delete();
        last_due = cyc;
        exp_pc = 32'h0;
        lat = 1;
        prev_hold = 1'b0;
        w_hs_prev = 1'b0;
        inject_spurious = 1'b1;
        step(0, 0, 32'h0, 1, 0);
        mark = n_out;
        for (int i = 0; i < 10; i++) step(0, 0, 32'h0, 2, 2);
        progress("after_reset_progress", mark);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "timeout");
    end

endmodule
